// File: rtl/riscv_pkg.sv
// Shared types and defaults for the RISC-V front end: fetch FSM states,
// the buffered {pc, instr} entry and the default reset vector.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        DRAIN
    } ifetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifetch_entry_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with registered head, flush and occupancy count.
// DEPTH must be a power of 2; push while full is accepted only alongside a pop.
module riscv_sync_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ifetch_entry_t
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_PUSH,
    input  T                         i_DATA,
    input  logic                     i_POP,
    input  logic                     i_FLUSH,
    output T                         o_DATA,
    output logic                     o_FULL,
    output logic                     o_EMPTY,
    output logic [$clog2(DEPTH):0]   o_COUNT
);

    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign w_pop  = i_POP && !o_EMPTY;
    assign w_push = i_PUSH && (!o_FULL || w_pop);

    always_ff @(posedge i_CLK) begin
        if (i_RST || i_FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; only the pointers and count
    // define which entries are meaningful.
    always_ff @(posedge i_CLK) begin
        if (w_push && !i_FLUSH) r_mem[r_wr_ptr] <= i_DATA;
    end

    assign o_DATA  = r_mem[r_rd_ptr];
    assign o_EMPTY = (r_count == '0);
    assign o_FULL  = (r_count == (AW+1)'(DEPTH));
    assign o_COUNT = r_count;

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit: credit-limited sequential fetch, in-order response
// tracking, redirect with flush/drop. Optional counters: RISCV_IFETCH_PERF_EN.
module riscv_ifetch
    import riscv_pkg::*;
#(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = BUS_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                   FIFO_DEPTH   = 4,
    parameter int                   ADDR_STEP    = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    output logic [BUS_WIDTH-1:0] o_ADDR,
    output logic                 o_REQ_VALID,
    input  logic                 i_REQ_READY,
    input  logic [BUS_WIDTH-1:0] i_DATA,
    input  logic                 i_RSP_VALID,
    output logic [BUS_WIDTH-1:0] o_INSTR,
    output logic [BUS_WIDTH-1:0] o_INSTR_PC,
    output logic                 o_INSTR_VALID,
    input  logic                 i_INSTR_READY,
    input  logic                 i_REDIRECT,
    input  logic [BUS_WIDTH-1:0] i_REDIRECT_PC
`ifdef RISCV_IFETCH_PERF_EN
    ,
    output logic [31:0]          o_FETCH_CNT,
    output logic [31:0]          o_DROP_CNT
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BUS_WIDTH-1:0] STEP = BUS_WIDTH'(ADDR_STEP);

    typedef struct packed {
        logic [BUS_WIDTH-1:0] pc;
        logic [BUS_WIDTH-1:0] instr;
    } entry_t;

    ifetch_state_t        r_state;
    ifetch_state_t        w_state_next;
    logic [BUS_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0] r_rsp_pc;
    logic [CW-1:0]        r_outstanding;
    logic [CW-1:0]        r_drop;
    logic                 r_started;

    logic [BUS_WIDTH-1:0] w_target;
    logic                 w_credit;
    logic                 w_accept;
    logic                 w_rsp;
    logic                 w_drop_hit;
    logic                 w_keep;
    logic                 w_pop;
    logic [CW-1:0]        w_outstanding_next;
    logic [CW-1:0]        w_drop_next;
    logic [CW-1:0]        w_count;
    logic                 w_empty;
    logic                 w_full;
    entry_t               w_push_entry;
    entry_t               w_head;

    assign w_target   = i_REDIRECT_PC & ~BUS_WIDTH'(3);
    assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CW+1)'(FIFO_DEPTH);
    assign w_accept   = o_REQ_VALID && i_REQ_READY;
    assign w_rsp      = i_RSP_VALID && (r_outstanding != '0);
    assign w_drop_hit = w_rsp && (r_drop != '0);
    assign w_keep     = w_rsp && (r_drop == '0);
    assign w_pop      = o_INSTR_VALID && i_INSTR_READY;

    always_comb begin
        case ({w_accept, w_rsp})
            2'b10:   w_outstanding_next = r_outstanding + 1'b1;
            2'b01:   w_outstanding_next = r_outstanding - 1'b1;
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    // A redirect orphans everything still in flight after this cycle's traffic.
    assign w_drop_next = i_REDIRECT ? w_outstanding_next : (r_drop - CW'(w_drop_hit));

    always_ff @(posedge i_CLK) begin
        if (i_RST) r_state <= FETCH;
        else       r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (i_REDIRECT)
            w_state_next = (w_drop_next != '0) ? DRAIN : FETCH;
        else if (r_state == DRAIN && w_drop_next == '0)
            w_state_next = FETCH;
    end

    // r_started keeps the request port quiet for the first cycle out of reset.
    always_comb begin
        o_REQ_VALID = r_started && (r_state == FETCH) && w_credit;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_addr        <= RESET_VECTOR;
            r_rsp_pc      <= RESET_VECTOR;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_started     <= 1'b0;
        end else begin
            r_started     <= 1'b1;
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_drop_next;
            if (i_REDIRECT) begin
                r_addr   <= w_target;
                r_rsp_pc <= w_target;
            end else begin
                if (w_accept) r_addr   <= r_addr + STEP;
                if (w_keep)   r_rsp_pc <= r_rsp_pc + STEP;
            end
        end
    end

    assign w_push_entry = '{pc: r_rsp_pc, instr: i_DATA};

    riscv_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_PUSH  (w_keep),
        .i_DATA  (w_push_entry),
        .i_POP   (w_pop),
        .i_FLUSH (i_REDIRECT),
        .o_DATA  (w_head),
        .o_FULL  (w_full),
        .o_EMPTY (w_empty),
        .o_COUNT (w_count)
    );

    assign o_ADDR        = r_addr;
    assign o_INSTR       = w_head.instr;
    assign o_INSTR_PC    = w_head.pc;
    assign o_INSTR_VALID = !w_empty;

`ifdef RISCV_IFETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_drop_cnt;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_fetch_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'(w_pop);
            r_drop_cnt  <= r_drop_cnt + 32'(w_drop_hit);
        end
    end

    assign o_FETCH_CNT = r_fetch_cnt;
    assign o_DROP_CNT  = r_drop_cnt;
`else
    // Counters compiled out; w_full only informs the credit invariant below.
`endif

    assert property (@(posedge i_CLK) disable iff (i_RST) i_RSP_VALID |-> (r_outstanding != '0));
    assert property (@(posedge i_CLK) disable iff (i_RST) w_keep |-> (!w_full || w_pop || i_REDIRECT));

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch with a 1-cycle in-order memory model
// whose response data is the bitwise inverse of the request address.
module tb_riscv_ifetch;

    logic        clk;
    logic        rst;
    logic [31:0] o_addr;
    logic        o_req_valid;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef RISCV_IFETCH_PERF_EN
    logic [31:0] o_fetch_cnt;
    logic [31:0] o_drop_cnt;
`endif

    riscv_ifetch dut (
        .i_CLK         (clk),
        .i_RST         (rst),
        .o_ADDR        (o_addr),
        .o_REQ_VALID   (o_req_valid),
        .i_REQ_READY   (req_ready),
        .i_DATA        (rsp_data),
        .i_RSP_VALID   (rsp_valid),
        .o_INSTR       (o_instr),
        .o_INSTR_PC    (o_instr_pc),
        .o_INSTR_VALID (o_instr_valid),
        .i_INSTR_READY (instr_ready),
        .i_REDIRECT    (redirect),
        .i_REDIRECT_PC (redirect_pc)
`ifdef RISCV_IFETCH_PERF_EN
        ,
        .o_FETCH_CNT   (o_fetch_cnt),
        .o_DROP_CNT    (o_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    bit          mem_hold;
    logic [31:0] mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_instr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: observe handshakes, advance one clock, update memory.
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        acc = !rst && o_req_valid && req_ready;
        a   = o_addr;
        if (!rst && o_instr_valid && instr_ready) begin
            dl_pc.push_back(o_instr_pc);
            dl_instr.push_back(o_instr);
        end
        if (acc) acc_log.push_back(a);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        if (rsp_valid && mem_q.size() > 0) mem_q.delete(0);
        if (acc) mem_q.push_back(a);
        if (rst) mem_q.delete();
        rsp_valid = !rst && !mem_hold && (mem_q.size() > 0);
        rsp_data  = (mem_q.size() > 0) ? ~mem_q[0] : 32'h0;
        @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        dl_pc.delete();
        dl_instr.delete();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        mem_hold = 1'b0;
        clear_logs();
    endtask

    task automatic run_until_acc(input int n);
        for (int i = 0; i < 200 && acc_log.size() < n; i++) cycle();
        check("acc_wait", acc_log.size(), n);
    endtask

    task automatic run_until_dl(input int n);
        for (int i = 0; i < 200 && dl_pc.size() < n; i++) cycle();
        check("dl_wait", dl_pc.size(), n);
    endtask

    initial begin
        rst         = 1'b1;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        mem_hold    = 1'b0;
        @(negedge clk);

        // Reset state
        cycle();
        cycle();
        check("rst_req_valid", o_req_valid, 0);
        check("rst_instr_valid", o_instr_valid, 0);
        check("rst_addr", o_addr, 32'h0);
`ifdef RISCV_IFETCH_PERF_EN
        check("rst_fetch_cnt", o_fetch_cnt, 0);
        check("rst_drop_cnt", o_drop_cnt, 0);
`endif

        // Streaming: addresses and delivered PCs in order
        reset_dut();
        req_ready   = 1'b1;
        instr_ready = 1'b1;
        run_until_acc(5);
        for (int i = 0; i < 5; i++) check($sformatf("stream_addr%0d", i), acc_log[i], 32'(4 * i));
        run_until_dl(3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream_pc%0d", i), dl_pc[i], 32'(4 * i));
            check($sformatf("stream_instr%0d", i), dl_instr[i], ~32'(4 * i));
        end

        // Decode stalled: credit limit of 4
        reset_dut();
        req_ready   = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        check("credit_acc_cnt", acc_log.size(), 4);
        check("credit_req_valid", o_req_valid, 0);
        check("credit_head_pc", o_instr_pc, 32'h0);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        check("credit_acc_cnt2", acc_log.size(), 5);
        check("credit_addr5", acc_log[4], 32'h10);
        check("credit_req_valid2", o_req_valid, 0);

        // Memory back-pressure holds the address
        reset_dut();
        req_ready   = 1'b1;
        instr_ready = 1'b1;
        run_until_acc(2);
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_addr%0d", i), o_addr, 32'h8);
            check($sformatf("stall_valid%0d", i), o_req_valid, 1);
            cycle();
        end
        req_ready = 1'b1;
        run_until_acc(3);
        check("stall_accept", acc_log[2], 32'h8);

        // Redirect with 2 outstanding requests
        reset_dut();
        req_ready   = 1'b1;
        instr_ready = 1'b1;
        mem_hold    = 1'b1;
        run_until_acc(2);
        req_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        check("redir_addr", o_addr, 32'h100);
        check("redir_req_valid", o_req_valid, 0);
        check("redir_instr_valid", o_instr_valid, 0);
        mem_hold  = 1'b0;
        req_ready = 1'b1;
        clear_logs();
        run_until_dl(1);
        check("redir_pc", dl_pc[0], 32'h100);
        check("redir_instr", dl_instr[0], ~32'h100);
        run_until_dl(5);
        check("redir_pc4", dl_pc[4], 32'h110);
`ifdef RISCV_IFETCH_PERF_EN
        check("perf_fetch_cnt", o_fetch_cnt, 5);
        check("perf_drop_cnt", o_drop_cnt, 2);
`endif

        // Misaligned redirect target and address wrap
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        cycle();
        check("align_addr", o_addr, 32'h100);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        check("wrap_target", o_addr, 32'hFFFF_FFFC);
        clear_logs();
        run_until_acc(2);
        check("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
        check("wrap_acc1", acc_log[1], 32'h0);
        run_until_dl(2);
        check("wrap_pc0", dl_pc[0], 32'hFFFF_FFFC);
        check("wrap_pc1", dl_pc[1], 32'h0);

        // Reset in the middle of a burst
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        check("midrst_req_valid", o_req_valid, 0);
        check("midrst_instr_valid", o_instr_valid, 0);
        check("midrst_addr", o_addr, 32'h0);
`ifdef RISCV_IFETCH_PERF_EN
        check("midrst_fetch_cnt", o_fetch_cnt, 0);
        check("midrst_drop_cnt", o_drop_cnt, 0);
`endif
        rst = 1'b0;
        clear_logs();
        run_until_dl(1);
        check("post_rst_pc", dl_pc[0], 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
